multicycle_ctrl_fsm: RTL and testbench

//  Multicycle control unit for the RV64I core. It sequences PC, IR, register file, ALU, memory and the

---
 rtl/core_pkg.sv | 66 ++++++
 rtl/ctrl_alu_decode.sv | 23 ++
 rtl/multicycle_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV64I multicycle control unit: FSM state
// encoding, opcode constants and the datapath mux/ALU select encodings.
// Optional feature macro used by the control FSM: EXC_TRAP_EN.
package core_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WB = 4'd6,
        MEM_WR = 4'd7,
        ALU_WB = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        JALR   = 4'd11,
        LUI    = 4'd12,
        TRAP   = 4'd13,
        ERR    = 4'd14
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MDR    = 2'b01,
        WB_PC     = 2'b10,
        WB_IMM    = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        SRC_A_PC   = 2'b00,
        SRC_A_RS1  = 2'b01,
        SRC_A_ZERO = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } src_b_e;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// R-type ALU operation decode: funct3 / funct7[5] -> alu_op.
// Encodings this core does not implement fall back to add.
module ctrl_alu_decode
    import core_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [2:0] alu_op
);

    // Pure lookup from the instruction function fields to the ALU select.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = funct7_b5 ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the RV64I core. Sequences one instruction at a
// time from FETCH to writeback and drives every datapath enable/mux select.
// Optional macro EXC_TRAP_EN: illegal opcodes save EPC and redirect the PC to
// TRAP_VECTOR; without it an illegal opcode is a one-cycle no-op.
module multicycle_ctrl_fsm
    import core_pkg::*;
#(
    parameter logic [63:0] TRAP_VECTOR = 64'h0000_0000_0000_00FF,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        epc_write,
    output logic        err,
    output logic [3:0]  state_o
);

    localparam int unsigned      CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             err_reg;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] r_alu_op;
    logic       taken;
    logic       mem_wait;
    logic       run;

    logic    pc_write_d, pc_write_cond_d, ir_write_d, mem_read_d, mem_write_d;
    logic    iord_d, reg_write_d, epc_write_d;
    wb_sel_e wb_sel_d;
    src_a_e  src_a_d;
    src_b_e  src_b_d;
    alu_op_e alu_op_d;

    // The trap target is muxed into the PC by the datapath, which shares this
    // parameter; only the opcode/funct fields of the IR steer control here.
    logic unused_inputs;
    assign unused_inputs = ^{instr[31], instr[29:15], instr[11:7], alu_lt, TRAP_VECTOR};

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    ctrl_alu_decode u_alu_decode (
        .funct3    (funct3),
        .funct7_b5 (instr[30]),
        .alu_op    (r_alu_op)
    );

    // Only beq/bne are resolved here; any other funct3 is treated as not taken.
    assign taken = (funct3 == 3'b000) ? alu_zero :
                   (funct3 == 3'b001) ? ~alu_zero : 1'b0;

    assign mem_wait = is_mem_wait_state(state_reg) && !mem_ready;

    // Next-state, Moore outputs and the memory-wait watchdog.
    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = '0;
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        ir_write_d      = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        iord_d          = 1'b0;
        reg_write_d     = 1'b0;
        epc_write_d     = 1'b0;
        wb_sel_d        = WB_ALUOUT;
        src_a_d         = SRC_A_PC;
        src_b_d         = SRC_B_RS2;
        alu_op_d        = ALU_ADD;

        case (state_reg)
            FETCH: begin
                mem_read_d = 1'b1;
                src_b_d    = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut while dispatching.
                src_b_d = SRC_B_IMM;
                case (opcode)
                    OP_R:          state_next = EXEC_R;
                    OP_IMM:        state_next = EXEC_I;
                    OP_LD, OP_SD:  state_next = ADDR;
                    OP_BR:         state_next = BRANCH;
                    OP_JALR:       state_next = JALR;
                    OP_JAL:        state_next = JAL;
                    OP_LUI:        state_next = LUI;
                    default:       state_next = TRAP;
                endcase
            end
            EXEC_R: begin
                src_a_d    = SRC_A_RS1;
                alu_op_d   = alu_op_e'(r_alu_op);
                state_next = ALU_WB;
            end
            EXEC_I: begin
                src_a_d    = SRC_A_RS1;
                src_b_d    = SRC_B_IMM;
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write_d = 1'b1;
                state_next  = FETCH;
            end
            ADDR: begin
                src_a_d    = SRC_A_RS1;
                src_b_d    = SRC_B_IMM;
                state_next = (opcode == OP_SD) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write_d = 1'b1;
                wb_sel_d    = WB_MDR;
                state_next  = FETCH;
            end
            MEM_WR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            BRANCH: begin
                src_a_d         = SRC_A_RS1;
                alu_op_d        = ALU_SUB;
                pc_write_cond_d = taken;
                state_next      = FETCH;
            end
            JAL: begin
                pc_write_d  = 1'b1;
                reg_write_d = 1'b1;
                wb_sel_d    = WB_PC;
                state_next  = FETCH;
            end
            JALR: begin
                pc_write_d  = 1'b1;
                reg_write_d = 1'b1;
                wb_sel_d    = WB_PC;
                src_a_d     = SRC_A_RS1;
                src_b_d     = SRC_B_IMM;
                state_next  = FETCH;
            end
            LUI: begin
                reg_write_d = 1'b1;
                wb_sel_d    = WB_IMM;
                state_next  = FETCH;
            end
            TRAP: begin
`ifdef EXC_TRAP_EN
                epc_write_d = 1'b1;
                pc_write_d  = 1'b1;
`else
                epc_write_d = 1'b0;
`endif
                state_next = FETCH;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Any cycle a request is held unanswered counts toward the timeout;
        // the counter clears itself on ready or on leaving the state.
        if (mem_wait) begin
            if (wait_cnt_reg == CNT_LAST) begin
                state_next = ERR;
            end else begin
                wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            end
        end
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == ERR) err_reg <= 1'b1;
        end
    end

    // Reset masks every output so no write can slip out during the reset cycle.
    assign run           = ~reset;
    assign pc_write      = run & pc_write_d;
    assign pc_write_cond = run & pc_write_cond_d;
    assign ir_write      = run & ir_write_d;
    assign mem_read      = run & mem_read_d;
    assign mem_write     = run & mem_write_d;
    assign iord          = run & iord_d;
    assign reg_write     = run & reg_write_d;
    assign epc_write     = run & epc_write_d;
    assign wb_sel        = wb_sel_d & {2{run}};
    assign alu_src_a     = src_a_d & {2{run}};
    assign alu_src_b     = src_b_d & {2{run}};
    assign alu_op        = alu_op_d & {3{run}};
    assign err           = run & err_reg;
    assign state_o       = state_reg & {4{run}};

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for multicycle_ctrl_fsm. Each table row is one
// clock cycle: inputs driven after the rising edge, outputs compared at the
// falling edge. Timeout and reset-during-wait are hand-written sequences.
module tb_multicycle_ctrl_fsm;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic        alu_zero = 1'b0;
    logic        alu_lt = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b;
    logic [2:0]  alu_op;
    logic        epc_write, err;
    logic [3:0]  state_o;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .epc_write     (epc_write),
        .err           (err),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    logic [17:0] out_bus;
    assign out_bus = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write,
                      wb_sel, alu_src_a, alu_src_b, alu_op, epc_write, err};

    function automatic logic [17:0] pk(input logic pcw, input logic pcc, input logic irw,
                                       input logic mr, input logic mw, input logic io,
                                       input logic rw, input logic [1:0] wb, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] op,
                                       input logic epc, input logic er);
        return {pcw, pcc, irw, mr, mw, io, rw, wb, sa, sb, op, epc, er};
    endfunction

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        zero;
        logic        rdy;
        state_e      st;
        logic [17:0] out;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic [31:0] ins, input logic zero, input logic rdy,
                       input state_e st, input logic [17:0] out);
        vec_t v;
        v.rst = rst; v.ins = ins; v.zero = zero; v.rdy = rdy; v.st = st; v.out = out;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input state_e exp_st, input logic [17:0] exp_out);
        checks++;
        if (state_o !== exp_st) begin
            errors++;
            $display("FAIL %s state_o got %0d expected %0d", name, state_o, exp_st);
        end
        checks++;
        if (out_bus !== exp_out) begin
            errors++;
            $display("FAIL %s outputs got %05h expected %05h", name, out_bus, exp_out);
        end else begin
            $display("ok   %s state %0d outputs %05h", name, state_o, out_bus);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [17:0] o_zero, f_rdy, f_wait, dec, exi, alu_wb, addr_o, mrd, mwb, mwr;
        logic [17:0] br_t, br_n, jal_o, jalr_o, lui_o, trap_o, err_o;
        logic [31:0] addi_i, sub_i, slt_i, and_i, ld_i, sd_i, beq_i, bne_i, jal_i, jalr_i, lui_i, bad_i;

        addi_i = 32'h0050_0093;  // addi x1,x0,5
        sub_i  = 32'h4020_81b3;  // sub  x3,x1,x2
        slt_i  = 32'h0020_a1b3;  // slt  x3,x1,x2
        and_i  = 32'h0020_f1b3;  // and  x3,x1,x2
        ld_i   = 32'h0000_b283;  // ld   x5,0(x1)
        sd_i   = 32'h0020_b023;  // sd   x2,0(x1)
        beq_i  = 32'h0020_8463;  // beq  x1,x2,8
        bne_i  = 32'h0020_9463;  // bne  x1,x2,8
        jal_i  = 32'h0080_00ef;  // jal  x1,8
        jalr_i = 32'h0000_80e7;  // jalr x1,0(x1)
        lui_i  = 32'h1234_52b7;  // lui  x5,0x12345
        bad_i  = 32'h0000_007f;  // opcode 1111111

        //           pcw pcc irw mr mw io rw  wb     sa     sb     op      epc err
        o_zero = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        f_rdy  = pk(1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
        f_wait = pk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
        dec    = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 3'b000, 0, 0);
        exi    = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0);
        alu_wb = pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        addr_o = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0);
        mrd    = pk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        mwb    = pk(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0);
        mwr    = pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        br_t   = pk(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b001, 0, 0);
        br_n   = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b001, 0, 0);
        jal_o  = pk(1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0);
        jalr_o = pk(1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 0, 0);
        lui_o  = pk(0, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 0, 0);
`ifdef EXC_TRAP_EN
        trap_o = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
`else
        trap_o = o_zero;
`endif
        err_o  = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1);

        // reset cycle: every output low
        add(1, addi_i, 0, 1, FETCH,  o_zero);
        // addi: F, D, EXEC_I, ALU_WB (reg_write only in cycle 4)
        add(0, addi_i, 0, 1, FETCH,  f_rdy);
        add(0, addi_i, 0, 1, DECODE, dec);
        add(0, addi_i, 0, 1, EXEC_I, exi);
        add(0, addi_i, 0, 1, ALU_WB, alu_wb);
        // R-type ops
        add(0, sub_i,  0, 1, FETCH,  f_rdy);
        add(0, sub_i,  0, 1, DECODE, dec);
        add(0, sub_i,  0, 1, EXEC_R, pk(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,3'b001,0,0));
        add(0, sub_i,  0, 1, ALU_WB, alu_wb);
        add(0, slt_i,  0, 1, FETCH,  f_rdy);
        add(0, slt_i,  0, 1, DECODE, dec);
        add(0, slt_i,  0, 1, EXEC_R, pk(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,3'b100,0,0));
        add(0, slt_i,  0, 1, ALU_WB, alu_wb);
        add(0, and_i,  0, 1, FETCH,  f_rdy);
        add(0, and_i,  0, 1, DECODE, dec);
        add(0, and_i,  0, 1, EXEC_R, pk(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,3'b010,0,0));
        add(0, and_i,  0, 1, ALU_WB, alu_wb);
        // ld with mem_ready held off 3 cycles in MEM_RD: 8 cycles total
        add(0, ld_i,   0, 1, FETCH,  f_rdy);
        add(0, ld_i,   0, 1, DECODE, dec);
        add(0, ld_i,   0, 1, ADDR,   addr_o);
        add(0, ld_i,   0, 0, MEM_RD, mrd);
        add(0, ld_i,   0, 0, MEM_RD, mrd);
        add(0, ld_i,   0, 0, MEM_RD, mrd);
        add(0, ld_i,   0, 1, MEM_RD, mrd);
        add(0, ld_i,   0, 1, MEM_WB, mwb);
        // sd: 4 cycles
        add(0, sd_i,   0, 1, FETCH,  f_rdy);
        add(0, sd_i,   0, 1, DECODE, dec);
        add(0, sd_i,   0, 1, ADDR,   addr_o);
        add(0, sd_i,   0, 1, MEM_WR, mwr);
        // beq taken / not taken, bne inverse
        add(0, beq_i,  1, 1, FETCH,  f_rdy);
        add(0, beq_i,  1, 1, DECODE, dec);
        add(0, beq_i,  1, 1, BRANCH, br_t);
        add(0, beq_i,  0, 1, FETCH,  f_rdy);
        add(0, beq_i,  0, 1, DECODE, dec);
        add(0, beq_i,  0, 1, BRANCH, br_n);
        add(0, bne_i,  0, 1, FETCH,  f_rdy);
        add(0, bne_i,  0, 1, DECODE, dec);
        add(0, bne_i,  0, 1, BRANCH, br_t);
        add(0, bne_i,  1, 1, FETCH,  f_rdy);
        add(0, bne_i,  1, 1, DECODE, dec);
        add(0, bne_i,  1, 1, BRANCH, br_n);
        // jumps, lui, illegal opcode
        add(0, jal_i,  0, 1, FETCH,  f_rdy);
        add(0, jal_i,  0, 1, DECODE, dec);
        add(0, jal_i,  0, 1, JAL,    jal_o);
        add(0, jalr_i, 0, 1, FETCH,  f_rdy);
        add(0, jalr_i, 0, 1, DECODE, dec);
        add(0, jalr_i, 0, 1, JALR,   jalr_o);
        add(0, lui_i,  0, 1, FETCH,  f_rdy);
        add(0, lui_i,  0, 1, DECODE, dec);
        add(0, lui_i,  0, 1, LUI,    lui_o);
        add(0, bad_i,  0, 1, FETCH,  f_rdy);
        add(0, bad_i,  0, 1, DECODE, dec);
        add(0, bad_i,  0, 1, TRAP,   trap_o);

        for (int i = 0; i < vt.size(); i++) begin
            reset     = vt[i].rst;
            instr     = vt[i].ins;
            alu_zero  = vt[i].zero;
            mem_ready = vt[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), vt[i].st, vt[i].out);
            step();
        end

        // Fetch never answered: 16 waiting cycles, then sticky ERR.
        reset = 1'b0;
        instr = addi_i;
        mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("timeout_wait%0d", k), FETCH, f_wait);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            mem_ready = k[0];
            @(negedge clk);
            check($sformatf("err_hold%0d", k), ERR, err_o);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        check("err_reset", FETCH, o_zero);
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("err_cleared", FETCH, f_rdy);
        step();

        // Reset while a store is waiting in MEM_WR.
        instr = sd_i;
        @(negedge clk); check("sd_dec", DECODE, dec);  step();
        @(negedge clk); check("sd_addr", ADDR, addr_o); step();
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("sd_wait%0d", k), MEM_WR, mwr);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        check("sd_reset", FETCH, o_zero);
        step();
        reset = 1'b0;
        // A fresh counter tolerates 15 unanswered fetch cycles without ERR.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_wait%0d", k), FETCH, f_wait);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_fetch", FETCH, f_rdy);
        step();
        @(negedge clk);
        check("post_rst_decode", DECODE, dec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
